// File: rtl/home_mem_responder.sv
// rtl/home_mem_responder.sv - home-memory block responder serving directory reads and write-backs after a fixed latency
// Optional build macro: HOME_MEM_STATS_EN adds saturating rd_count/wr_count response counters.
module home_mem_responder #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 1,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_data
`ifdef HOME_MEM_STATS_EN
    ,
    output logic [7:0]        rd_count,
    output logic [7:0]        wr_count
`endif
);

    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                w_accept;
    logic                w_commit;
    logic                w_consume;

    assign rsp_write = r_rsp_write;
    assign rsp_data  = r_rsp_data;

    // State register; reset always lands in IDLE so req_ready is up as soon as reset drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode; req_ready and rsp_valid depend on state only.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        w_accept  = 1'b0;
        w_commit  = 1'b0;
        w_consume = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_commit = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_consume = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, latency countdown and response registers frozen until the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= LOAD;
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_data;
            end else if (r_state == S_ACCESS && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rsp_write <= r_write;
                r_rsp_data  <= r_write ? '0 : r_mem[r_addr];
            end
        end
    end

    // Block array; a write lands only at its commit edge, so reset discards one still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit && r_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

`ifdef HOME_MEM_STATS_EN
    logic [7:0] r_rd_count;
    logic [7:0] r_wr_count;

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;

    // Saturating counts of consumed read and write-back responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_count <= 8'd0;
            r_wr_count <= 8'd0;
        end else if (w_consume) begin
            if (r_rsp_write) begin
                if (r_wr_count != 8'hFF) r_wr_count <= r_wr_count + 8'd1;
            end else begin
                if (r_rd_count != 8'hFF) r_rd_count <= r_rd_count + 8'd1;
            end
        end
    end
`endif

endmodule
